// File: rtl/spi_mem_pkg.sv
// spi_mem_pkg: shared constants and types for the SPI memory controller.
//   CMD_*    : SPI command bytes (read, write, fast read)
//   state_e  : controller FSM states
//   port_e   : requester select (fetch / data)
package spi_mem_pkg;
   localparam logic [7:0] CMD_READ      = 8'h03;
   localparam logic [7:0] CMD_WRITE     = 8'h02;
   localparam logic [7:0] CMD_FAST_READ = 8'h0B;

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_e;
   typedef enum logic       {PORT_IF, PORT_D}      port_e;
endpackage

// File: rtl/spi_mem_shifter.sv
// spi_mem_shifter: bit engine for one SPI mode-0 transaction, MSB first.
//   clk, rst_n   : system clock, async active-low reset
//   start_i      : load word_i/nbits_i and begin shifting (next cycle = first low phase)
//   word_i       : left-aligned shift word; only the top nbits_i bits are sent
//   nbits_i      : number of bits in this transaction
//   spi_clk_o    : SPI clock, idle low, HALF_PERIOD cycles per phase
//   spi_mosi_o   : serial out, changes only at the start of a low phase
//   spi_miso_i   : serial in, sampled in the first cycle of each high phase
//   rx_nxt_o     : last 8 received bits, including a sample taken this cycle
//   last_o       : high in the final cycle of the final bit
module spi_mem_shifter #(
   parameter int NB_MAX      = 32,
   parameter int HALF_PERIOD = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        start_i,
   input  logic [NB_MAX-1:0]           word_i,
   input  logic [$clog2(NB_MAX+1)-1:0] nbits_i,
   output logic                        spi_clk_o,
   output logic                        spi_mosi_o,
   input  logic                        spi_miso_i,
   output logic [7:0]                  rx_nxt_o,
   output logic                        last_o
);
   localparam int CNT_W = $clog2(NB_MAX+1);
   localparam int DIV_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

   logic              active_q, clk_q, mosi_q;
   logic [NB_MAX-1:0] sh_q;
   logic [DIV_W-1:0]  div_q;
   logic [CNT_W-1:0]  left_q;
   logic [7:0]        rx_q;
   logic              phase_end, sample;

   assign phase_end  = (div_q == DIV_W'(HALF_PERIOD-1));
   assign sample     = active_q && clk_q && (div_q == '0);
   assign last_o     = active_q && clk_q && phase_end && (left_q == CNT_W'(1));
   // With HALF_PERIOD=1 the final sample and the final cycle coincide, so
   // expose the byte as it will be after this cycle's sample.
   assign rx_nxt_o   = sample ? {rx_q[6:0], spi_miso_i} : rx_q;
   assign spi_clk_o  = clk_q;
   assign spi_mosi_o = mosi_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q <= 1'b0;
         clk_q    <= 1'b0;
         mosi_q   <= 1'b0;
         sh_q     <= '0;
         div_q    <= '0;
         left_q   <= '0;
         rx_q     <= '0;
      end else if (start_i) begin
         active_q <= 1'b1;
         clk_q    <= 1'b0;
         mosi_q   <= word_i[NB_MAX-1];
         sh_q     <= word_i << 1;
         div_q    <= '0;
         left_q   <= nbits_i;
      end else if (active_q) begin
         if (sample) rx_q <= {rx_q[6:0], spi_miso_i};
         if (phase_end) begin
            div_q <= '0;
            if (!clk_q) begin
               clk_q <= 1'b1;
            end else begin
               clk_q  <= 1'b0;
               left_q <= left_q - CNT_W'(1);
               if (left_q == CNT_W'(1)) begin
                  active_q <= 1'b0;
                  mosi_q   <= 1'b0;
               end else begin
                  mosi_q <= sh_q[NB_MAX-1];
                  sh_q   <= sh_q << 1;
               end
            end
         end else begin
            div_q <= div_q + DIV_W'(1);
         end
      end
   end
endmodule

// File: rtl/spi_mem_ctrl.sv
// spi_mem_ctrl: shares one SPI memory bus between instruction fetch (read-only)
// and data (read/write). Each grant is one transaction: command, address bytes,
// one data byte; mode 0, MSB first.
//   clk, rst_n               : system clock, async active-low reset
//   if_req/if_addr/if_ack    : fetch read port
//   d_req/d_we/d_addr/d_wdata/d_ack : data port
//   rdata                    : last read byte (both ports), valid in the ack cycle
//   busy                     : controller not idle
//   spi_clk/spi_mosi/spi_miso/spi_cs_n : SPI bus
// Build option: SPI_MEM_FAST_READ_EN selects fast read (0x0B + 8 dummy bits).
module spi_mem_ctrl
   import spi_mem_pkg::*;
#(
   parameter int ADDR_W      = 16,
   parameter int HALF_PERIOD = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [7:0]        d_wdata,
   output logic              d_ack,
   output logic [7:0]        rdata,
   output logic              busy,
   output logic              spi_clk,
   output logic              spi_mosi,
   input  logic              spi_miso,
   output logic              spi_cs_n
);
`ifdef SPI_MEM_FAST_READ_EN
   localparam int         DUMMY  = 8;
   localparam logic [7:0] RD_CMD = CMD_FAST_READ;
`else
   localparam int         DUMMY  = 0;
   localparam logic [7:0] RD_CMD = CMD_READ;
`endif
   localparam int NB_WR  = 16 + ADDR_W;
   localparam int NB_RD  = NB_WR + DUMMY;
   localparam int NB_MAX = NB_RD;
   localparam int CNT_W  = $clog2(NB_MAX+1);

   state_e            state_q;
   port_e             port_q, last_q, gnt_d;
   logic              we_q, we_d, cs_n_q, if_ack_q, d_ack_q;
   logic [7:0]        rdata_q, rx_nxt;
   logic [NB_MAX-1:0] word_d;
   logic [CNT_W-1:0]  nbits_d;
   logic              any_req, start, sh_last;

   assign any_req = if_req | d_req;
   assign start   = (state_q == IDLE) && any_req;

   // Round robin on a tie: whoever was not served last goes first.
   always_comb begin
      gnt_d = PORT_D;
      if (if_req && d_req) gnt_d = (last_q == PORT_D) ? PORT_IF : PORT_D;
      else if (if_req)     gnt_d = PORT_IF;
   end

   // Left-aligned transaction word; read data byte and dummy bits go out as 0.
   always_comb begin
      we_d    = (gnt_d == PORT_D) && d_we;
      word_d  = '0;
      word_d[NB_MAX-1 -: 8]      = we_d ? CMD_WRITE : RD_CMD;
      word_d[NB_MAX-9 -: ADDR_W] = (gnt_d == PORT_D) ? d_addr : if_addr;
      if (we_d) word_d[NB_MAX-9-ADDR_W -: 8] = d_wdata;
      nbits_d = we_d ? CNT_W'(NB_WR) : CNT_W'(NB_RD);
   end

   spi_mem_shifter #(
      .NB_MAX      (NB_MAX),
      .HALF_PERIOD (HALF_PERIOD)
   ) u_shifter (
      .clk        (clk),
      .rst_n      (rst_n),
      .start_i    (start),
      .word_i     (word_d),
      .nbits_i    (nbits_d),
      .spi_clk_o  (spi_clk),
      .spi_mosi_o (spi_mosi),
      .spi_miso_i (spi_miso),
      .rx_nxt_o   (rx_nxt),
      .last_o     (sh_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         port_q   <= PORT_D;
         last_q   <= PORT_IF;
         we_q     <= 1'b0;
         cs_n_q   <= 1'b1;
         if_ack_q <= 1'b0;
         d_ack_q  <= 1'b0;
         rdata_q  <= '0;
      end else begin
         if_ack_q <= 1'b0;
         d_ack_q  <= 1'b0;
         case (state_q)
            IDLE: if (any_req) begin
               port_q  <= gnt_d;
               we_q    <= we_d;
               cs_n_q  <= 1'b0;
               state_q <= SHIFT;
            end
            SHIFT: if (sh_last) begin
               cs_n_q  <= 1'b1;
               state_q <= FINISH;
               last_q  <= port_q;
               if (port_q == PORT_IF) if_ack_q <= 1'b1;
               else                   d_ack_q  <= 1'b1;
               if (!we_q) rdata_q <= rx_nxt;
            end
            FINISH:  state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign if_ack   = if_ack_q;
   assign d_ack    = d_ack_q;
   assign rdata    = rdata_q;
   assign spi_cs_n = cs_n_q;
   assign busy     = (state_q != IDLE);
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// tb_spi_mem_ctrl: three controller instances (16b/HP1, 16b/HP3, 24b/HP1),
// a serial-memory responder per instance, a transaction-level reference model
// compared every cycle, and directed transactions with literal expectations.
`timescale 1ns/1ps
module tb_spi_mem_ctrl;
   localparam int NI = 3;
`ifdef SPI_MEM_FAST_READ_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   function automatic int aw(int k); return (k == 2) ? 24 : 16; endfunction
   function automatic int hp(int k); return (k == 1) ? 3 : 1;   endfunction
   function automatic int nb(int k, bit we); return 16 + aw(k) + ((FAST && !we) ? 8 : 0); endfunction

   logic       clk = 1'b0, rst_n = 1'b0;
   logic       if_req [NI], d_req [NI], d_we [NI], miso [NI];
   logic [23:0] if_addr [NI], d_addr [NI];
   logic [7:0] d_wdata [NI], resp_byte [NI];
   logic       if_ack [NI], d_ack [NI], busy [NI], sclk [NI], mosi [NI], cs_n [NI];
   logic [7:0] rdata [NI];

   int n_chk = 0, n_fail = 0, cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   spi_mem_ctrl #(.ADDR_W(16), .HALF_PERIOD(1)) u0 (
      .clk(clk), .rst_n(rst_n), .if_req(if_req[0]), .if_addr(if_addr[0][15:0]), .if_ack(if_ack[0]),
      .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0][15:0]), .d_wdata(d_wdata[0]), .d_ack(d_ack[0]),
      .rdata(rdata[0]), .busy(busy[0]), .spi_clk(sclk[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]), .spi_cs_n(cs_n[0]));
   spi_mem_ctrl #(.ADDR_W(16), .HALF_PERIOD(3)) u1 (
      .clk(clk), .rst_n(rst_n), .if_req(if_req[1]), .if_addr(if_addr[1][15:0]), .if_ack(if_ack[1]),
      .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1][15:0]), .d_wdata(d_wdata[1]), .d_ack(d_ack[1]),
      .rdata(rdata[1]), .busy(busy[1]), .spi_clk(sclk[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]), .spi_cs_n(cs_n[1]));
   spi_mem_ctrl #(.ADDR_W(24), .HALF_PERIOD(1)) u2 (
      .clk(clk), .rst_n(rst_n), .if_req(if_req[2]), .if_addr(if_addr[2]), .if_ack(if_ack[2]),
      .d_req(d_req[2]), .d_we(d_we[2]), .d_addr(d_addr[2]), .d_wdata(d_wdata[2]), .d_ack(d_ack[2]),
      .rdata(rdata[2]), .busy(busy[2]), .spi_clk(sclk[2]), .spi_mosi(mosi[2]), .spi_miso(miso[2]), .spi_cs_n(cs_n[2]));

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- serial memory responder + mosi capture ----------------
   // Read data bit is presented through the low phase and the first high
   // cycle; later high cycles carry the inverted bit, so a late sample shows.
   int          r_idx [NI], r_hi [NI], ifack_cnt [NI];
   bit          r_prev [NI], r_cs [NI];
   logic [63:0] cap [NI];

   function automatic logic rx_bit(int k, int idx);
      int n;
      n = nb(k, 1'b0);
      if (idx >= n - 8 && idx < n) return resp_byte[k][n-1-idx];
      return 1'($urandom_range(0, 1));
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         if (if_ack[k] === 1'b1) ifack_cnt[k]++;
         if (cs_n[k] !== 1'b0) begin
            r_idx[k] = 0; r_hi[k] = 0; r_prev[k] = 1'b0; r_cs[k] = 1'b1;
            miso[k] = 1'($urandom_range(0, 1));
         end else begin
            if (r_cs[k]) cap[k] = '0;
            r_cs[k] = 1'b0;
            if (sclk[k] === 1'b0) begin
               if (r_prev[k]) r_idx[k]++;
               r_prev[k] = 1'b0; r_hi[k] = 0;
               miso[k] = rx_bit(k, r_idx[k]);
            end else begin
               if (r_hi[k] == 0) cap[k] = {cap[k][62:0], mosi[k]};
               else              miso[k] = ~rx_bit(k, r_idx[k]);
               r_prev[k] = 1'b1; r_hi[k]++;
            end
         end
      end
   end

   // ---------------- reference model and per-cycle compare ----------------
   bit          m_act [NI], m_port [NI], m_we [NI], m_last [NI];
   int          m_o [NI], m_nb [NI];
   logic [63:0] m_stream [NI];
   logic [7:0]  m_resp [NI], m_rdata [NI];

   always @(negedge clk) begin
      for (int k = 0; k < NI; k++) begin
         logic [13:0] act_v, exp_v, mask;
         logic [63:0] a, s;
         int          o, t, b;
         bit          p;
         act_v = {cs_n[k], sclk[k], mosi[k], if_ack[k], d_ack[k], busy[k], rdata[k]};
         mask  = '1;
         if (!rst_n) begin
            m_act[k] = 1'b0; m_last[k] = 1'b0; m_rdata[k] = 8'h00;
            exp_v = {6'b100000, 8'h00};
         end else if (!m_act[k]) begin
            exp_v = {6'b100000, m_rdata[k]};
            mask[11] = 1'b0;
            if (if_req[k] || d_req[k]) begin
               p = (if_req[k] && d_req[k]) ? !m_last[k] : d_req[k];
               m_act[k] = 1'b1; m_o[k] = 0; m_port[k] = p;
               m_we[k] = p && d_we[k];
               m_resp[k] = resp_byte[k];
               m_nb[k] = nb(k, m_we[k]);
               a = p ? 64'(d_addr[k]) : 64'(if_addr[k]);
               a = a & ((64'd1 << aw(k)) - 64'd1);
               s = m_we[k] ? 64'h02 : (FAST ? 64'h0B : 64'h03);
               s = (s << aw(k)) | a;
               if (FAST && !m_we[k]) s = s << 8;
               s = (s << 8) | (m_we[k] ? 64'(d_wdata[k]) : 64'h0);
               m_stream[k] = s;
            end
         end else begin
            m_o[k]++;
            o = m_o[k];
            t = 2 * m_nb[k] * hp(k);
            if (o <= t) begin
               b = (o - 1) / (2 * hp(k));
               exp_v = {1'b0, 1'(((o - 1) % (2 * hp(k))) >= hp(k)), m_stream[k][m_nb[k]-1-b],
                        3'b001, m_rdata[k]};
            end else begin
               if (!m_we[k]) m_rdata[k] = m_resp[k];
               exp_v = {3'b100, !m_port[k], m_port[k], 1'b1, m_rdata[k]};
               mask[11] = 1'b0;
               m_last[k] = m_port[k];
               m_act[k] = 1'b0;
            end
         end
         chk($sformatf("u%0d cyc%0d outputs{cs_n,sclk,mosi,if_ack,d_ack,busy,rdata}", k, cyc),
             64'(act_v & mask), 64'(exp_v & mask));
      end
   end

   // ---------------- stimulus ----------------
   task automatic txn(int k, bit port, bit we, logic [23:0] addr, logic [7:0] wd,
                      logic [7:0] resp, output int lat);
      int t0;
      bit got;
      @(posedge clk); #1;
      resp_byte[k] = resp;
      if (port) begin d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd; d_req[k] = 1'b1; end
      else      begin if_addr[k] = addr; if_req[k] = 1'b1; end
      t0 = cyc; got = 1'b0; lat = -1;
      for (int i = 0; i < 400 && !got; i++) begin
         @(negedge clk);
         if ((port ? d_ack[k] : if_ack[k]) === 1'b1) begin got = 1'b1; lat = cyc - t0; end
         if (i == 2) begin   // changes after grant must not matter
            if (port) begin d_addr[k] = ~addr; d_wdata[k] = ~wd; d_we[k] = ~we; end
            else if_addr[k] = ~addr;
         end
      end
      chk($sformatf("u%0d ack seen", k), 64'(got), 64'd1);
      @(posedge clk); #1;
      if_req[k] = 1'b0; d_req[k] = 1'b0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1; rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1; rst_n = 1'b1;
   endtask

   initial begin
      int   lat, cnt0, nack;
      logic [3:0] order;
      for (int k = 0; k < NI; k++) begin
         if_req[k] = 0; d_req[k] = 0; d_we[k] = 0; if_addr[k] = 0; d_addr[k] = 0;
         d_wdata[k] = 0; resp_byte[k] = 0; ifack_cnt[k] = 0; cap[k] = 0;
      end
      repeat (2) @(negedge clk);
      chk("reset cs_n", 64'(cs_n[0]), 64'd1);
      chk("reset spi_clk", 64'(sclk[0]), 64'd0);
      chk("reset rdata", 64'(rdata[2]), 64'd0);
      @(posedge clk); #1; rst_n = 1'b1;

      // fetch read 0x1234 -> A5
      txn(0, 1'b0, 1'b0, 24'h1234, 8'h00, 8'hA5, lat);
      chk("fetch latency", 64'(lat), FAST ? 64'd81 : 64'd65);
      chk("fetch mosi stream", cap[0], FAST ? 64'h0B12340000 : 64'h03123400);
      chk("fetch rdata", 64'(rdata[0]), 64'hA5);

      // data write 0xBEEF <- 5A
      cnt0 = ifack_cnt[0];
      txn(0, 1'b1, 1'b1, 24'hBEEF, 8'h5A, 8'h11, lat);
      chk("write latency", 64'(lat), 64'd65);
      chk("write mosi stream", cap[0], 64'h02BEEF5A);
      chk("write keeps rdata", 64'(rdata[0]), 64'hA5);
      chk("write no if_ack", 64'(ifack_cnt[0] - cnt0), 64'd0);

      // simultaneous requests from reset: data, fetch, data, fetch
      do_reset();
      @(posedge clk); #1;
      resp_byte[0] = 8'h77; if_addr[0] = 24'h0200;
      d_addr[0] = 24'h0100; d_we[0] = 1'b1; d_wdata[0] = 8'hC6;
      if_req[0] = 1'b1; d_req[0] = 1'b1;
      nack = 0; order = '0;
      for (int i = 0; i < 800 && nack < 4; i++) begin
         @(negedge clk);
         if (d_ack[0] === 1'b1 || if_ack[0] === 1'b1) begin
            order = {order[2:0], d_ack[0] === 1'b1};
            nack++;
         end
      end
      @(posedge clk); #1; if_req[0] = 1'b0; d_req[0] = 1'b0;
      chk("arb ack count", 64'(nack), 64'd4);
      chk("arb order (1=data)", 64'(order), 64'b1010);
      chk("arb rdata", 64'(rdata[0]), 64'h77);

      // HALF_PERIOD=3 read at 0x0001
      txn(1, 1'b1, 1'b0, 24'h0001, 8'h00, 8'h3C, lat);
      chk("hp3 latency", 64'(lat), FAST ? 64'd241 : 64'd193);
      chk("hp3 mosi stream", cap[1], FAST ? 64'h0B00010000 : 64'h03000100);
      chk("hp3 rdata", 64'(rdata[1]), 64'h3C);

      // reset in the middle of a read (bit 10 low phase)
      @(posedge clk); #1;
      resp_byte[0] = 8'h99; if_addr[0] = 24'h4321; if_req[0] = 1'b1;
      repeat (21) @(posedge clk);
      #1;
      chk("mid-txn busy", 64'(busy[0]), 64'd1);
      chk("mid-txn cs_n", 64'(cs_n[0]), 64'd0);
      rst_n = 1'b0; if_req[0] = 1'b0;
      @(negedge clk);
      chk("abort cs_n", 64'(cs_n[0]), 64'd1);
      chk("abort spi_clk", 64'(sclk[0]), 64'd0);
      chk("abort if_ack", 64'(if_ack[0]), 64'd0);
      repeat (2) @(posedge clk);
      #1; rst_n = 1'b1;
      txn(0, 1'b0, 1'b0, 24'h4321, 8'h00, 8'h99, lat);
      chk("post-reset latency", 64'(lat), FAST ? 64'd81 : 64'd65);
      chk("post-reset rdata", 64'(rdata[0]), 64'h99);

      // 24-bit address read
      txn(2, 1'b0, 1'b0, 24'h012345, 8'h00, 8'hC3, lat);
      chk("a24 latency", 64'(lat), FAST ? 64'd97 : 64'd81);
      chk("a24 mosi stream", cap[2], FAST ? 64'h0B0123450000 : 64'h0301234500);
      chk("a24 rdata", 64'(rdata[2]), 64'hC3);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
      $fatal(1, "watchdog");
   end
endmodule
